cla_sub_serial: RTL and testbench
=================================

# cla_sub_serial

Sequential nibble-serial subtractor: the inverse of the team's 4-bit carry-lookahead adder. It accepts two WIDTH-bit operands over a valid/ready handshake and computes A − B one 4-bit borrow-lookahead slice per cycle, LSB nibble first, with a registered borrow between nibbles. It returns the difference plus unsigned-borrow, signed-overflow and zero flags over a second valid/ready handshake. It sits alongside the adder in the datapath wherever a compact, multi-cycle subtract/compare is acceptable.

## Interface
- WIDTH, 16, operand width in bits; multiple of 4, ≥ 4; NIB = WIDTH/4
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  minuend, sampled on accept
- b  input  WIDTH  subtrahend, sampled on accept
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  (a − b) mod 2^WIDTH
- borrow  output  1  1 when a < b (unsigned)
- ovf  output  1  signed overflow of a − b
- zero  output  1  diff == 0

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid & in_ready, latch a and b, clear the borrow register, clear the nibble counter, and go to RUN.
- RUN: each cycle, slice i computes nibble i of diff from a[4i+3:4i], b[4i+3:4i] and the registered borrow-in. It writes the nibble into the diff register and registers borrow-out. The counter increments. After nibble NIB−1, go to DONE.
- Slice equations per bit: g = ~a & b, p = ~(a ^ b), d = a ^ b ^ bin. Borrow lookahead: bout = g3 | p3g2 | p3p2g1 | p3p2p1g0 | p3p2p1p0·bin. This is fully parallel within the slice; no ripple.
- Borrow into nibble 0 is 0.
- DONE: out_valid=1 and diff/borrow/ovf/zero are held stable. On out_valid & out_ready, go to IDLE.
- Flags are set on entry to DONE:
  - borrow = final borrow-out.
  - ovf = (a[MSB] ≠ b[MSB]) & (diff[MSB] ≠ a[MSB]).
  - zero = (diff == 0).
- Operand changes on a/b after accept are ignored.
- in_valid while not IDLE is ignored; the source holds until in_ready.
- Reset (async, any state): state=IDLE, out_valid=0, diff=0, borrow=0, ovf=0, zero=0, internal operand/borrow/counter=0. in_ready=1 once rst_n deasserts. A reset mid-RUN or mid-DONE aborts the operation and produces no result.

## Timing
- Accept at rising edge E0. RUN occupies cycles E0..E0+NIB−1. out_valid rises after edge E0+NIB, giving latency NIB cycles (4 for WIDTH=16).
- All outputs are registered. in_ready decodes from the state register only, with no combinational path from in_valid or out_ready.
- Result handshake at edge Er moves the block to IDLE. in_ready=1 in the following cycle, so there is one bubble: minimum issue interval NIB+2 cycles.
- The counter is $clog2(NIB) bits, minimum 1. NIB=1 (WIDTH=4) gives exactly one RUN cycle.
- out_ready held low keeps DONE indefinitely with outputs unchanged.

## Structure
- Shared package: state enum {IDLE, RUN, DONE} and constant NIBBLE_W=4.
- Sub-module bla4: combinational 4-bit borrow-lookahead slice with inputs a[3:0], b[3:0], bin and outputs d[3:0], bout. Instantiate once and time-share it across nibbles.
- Top level holds the FSM, counter, operand/diff shift or index registers, and flag logic.

## Test plan
- WIDTH=16, 0x1234 − 0x0234 → diff=0x1000, borrow=0, ovf=0, zero=0. out_valid exactly 4 cycles after accept.
- 0x0000 − 0x0001 → diff=0xFFFF, borrow=1, ovf=0, zero=0. Borrow propagates through all 4 nibbles.
- 0x8000 − 0x0001 → diff=0x7FFF, borrow=0, ovf=1. 0x7FFF − 0xFFFF → diff=0x8000, borrow=1, ovf=1.
- 0xA5A5 − 0xA5A5 → diff=0x0000, zero=1, borrow=0. Then hold out_ready=0 for 5 cycles: outputs stable, in_ready=0, new in_valid ignored.
- Assert rst_n=0 in the 2nd RUN cycle → all outputs 0 immediately and in_ready=1 after release. The next operation 0x0010 − 0x0001 → 0x000F is correct.
- WIDTH=4: 0x3 − 0x5 → diff=0xE, borrow=1, ovf=0, latency 1. Back-to-back issue interval measured at 3 cycles.

Source files
------------

// File: rtl/cla_sub_serial_pkg.sv
// Shared types and constants for the nibble-serial
// borrow-lookahead subtractor.
package cla_sub_serial_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_sub_serial_bla4.sv
// Combinational 4-bit borrow-lookahead slice.
// All internal borrows are formed in parallel from g/p.
module cla_sub_serial_bla4
  import cla_sub_serial_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_a,
  input  logic [NIBBLE_W-1:0] i_b,
  input  logic                i_bin,
  output logic [NIBBLE_W-1:0] o_d,
  output logic                o_bout
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_c;

  assign w_g = ~i_a & i_b;
  assign w_p = ~(i_a ^ i_b);

  assign w_c[0] = i_bin;
  assign w_c[1] = w_g[0]
                | (w_p[0] & i_bin);
  assign w_c[2] = w_g[1]
                | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & i_bin);
  assign w_c[3] = w_g[2]
                | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_bin);

  assign o_bout = w_g[3]
                | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (&w_p & i_bin);

  assign o_d = i_a ^ i_b ^ w_c;

endmodule

// File: rtl/cla_sub_serial.sv
// Nibble-serial subtractor: one borrow-lookahead slice
// time-shared across nibbles, LSB first.
module cla_sub_serial
  import cla_sub_serial_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  state_t            r_state;
  state_t            w_state_nx;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_diff;
  logic [WIDTH-1:0]  w_diff_nx;
  logic [CW-1:0]     r_cnt;
  logic              r_bin;
  logic              r_borrow;
  logic              r_ovf;
  logic              r_zero;
  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_d;
  logic              w_bout;
  logic              w_last;
  logic              w_ovf;

  assign w_a_nib = r_a[32'(r_cnt)*NIBBLE_W +: NIBBLE_W];
  assign w_b_nib = r_b[32'(r_cnt)*NIBBLE_W +: NIBBLE_W];
  assign w_last  = (r_cnt == LAST);

  cla_sub_serial_bla4 u_bla4 (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_bin  (r_bin),
    .o_d    (w_d),
    .o_bout (w_bout)
  );

  always_comb begin
    w_diff_nx = r_diff;
    w_diff_nx[32'(r_cnt)*NIBBLE_W +: NIBBLE_W] = w_d;
  end

  assign w_ovf = (r_a[WIDTH-1] ^ r_b[WIDTH-1])
               & (w_diff_nx[WIDTH-1] ^ r_a[WIDTH-1]);

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)  w_state_nx = RUN;
      RUN:     if (w_last)    w_state_nx = DONE;
      DONE:    if (out_ready) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_bin    <= 1'b0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a   <= a;
            r_b   <= b;
            r_bin <= 1'b0;
            r_cnt <= '0;
          end
        end
        RUN: begin
          r_diff <= w_diff_nx;
          r_bin  <= w_bout;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            r_borrow <= w_bout;
            r_ovf    <= w_ovf;
            r_zero   <= (w_diff_nx == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign diff      = r_diff;
  assign borrow    = r_borrow;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_cla_sub_serial.sv
// Directed bench: 16-bit and 4-bit instances,
// hand-computed differences and flags.
module tb_cla_sub_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        iv16 = 1'b0;
  logic        ir16;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        ov16;
  logic        or16 = 1'b0;
  logic [15:0] d16;
  logic        bo16, vf16, z16;

  logic        iv4 = 1'b0;
  logic        ir4;
  logic [3:0]  a4 = '0;
  logic [3:0]  b4 = '0;
  logic        ov4;
  logic        or4 = 1'b0;
  logic [3:0]  d4;
  logic        bo4, vf4, z4;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cla_sub_serial #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(or16),
    .diff(d16), .borrow(bo16),
    .ovf(vf16), .zero(z16)
  );

  cla_sub_serial #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(or4),
    .diff(d4), .borrow(bo4),
    .ovf(vf4), .zero(z4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op16(input string tag,
                      input logic [15:0] ta,
                      input logic [15:0] tb,
                      input logic [15:0] ed,
                      input logic eb, input logic eo,
                      input logic ez, input bit hs);
    int n;
    int lat;
    n = 0;
    while (!ir16 && n < 20) begin
      step();
      n++;
    end
    chk({tag, ".rdy"}, 32'(ir16), 1);
    iv16 = 1'b1;
    a16  = ta;
    b16  = tb;
    step();
    iv16 = 1'b0;
    a16  = 16'hDEAD;
    b16  = 16'hBEEF;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!ov16 && lat < 20);
    chk({tag, ".lat"}, 32'(lat), 4);
    chk({tag, ".diff"}, 32'(d16), 32'(ed));
    chk({tag, ".flags"}, {29'd0, bo16, vf16, z16},
        {29'd0, eb, eo, ez});
    if (hs) begin
      or16 = 1'b1;
      step();
      or16 = 1'b0;
      chk({tag, ".drop"}, 32'(ov16), 0);
    end
  endtask

  initial begin
    int acc[$];
    #12;
    chk("rst.ready", 32'(ir16), 1);
    chk("rst.valid", 32'(ov16), 0);
    chk("rst.out", {12'd0, d16, bo16, vf16, z16}, 0);
    rst_n = 1'b1;
    step();

    op16("basic", 16'h1234, 16'h0234,
         16'h1000, 1'b0, 1'b0, 1'b0, 1'b1);
    op16("under", 16'h0000, 16'h0001,
         16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    op16("negovf", 16'h8000, 16'h0001,
         16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b1);
    op16("eq", 16'hA5A5, 16'hA5A5,
         16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);

    iv16 = 1'b1;
    a16  = 16'h1111;
    b16  = 16'h2222;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold.valid", 32'(ov16), 1);
      chk("hold.ready", 32'(ir16), 0);
      chk("hold.out", {12'd0, d16, bo16, vf16, z16},
          {12'd0, 16'h0000, 3'b001});
    end
    iv16 = 1'b0;
    or16 = 1'b1;
    step();
    or16 = 1'b0;

    op16("posovf", 16'h7FFF, 16'hFFFF,
         16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);

    iv16 = 1'b1;
    a16  = 16'h1234;
    b16  = 16'h0001;
    step();
    iv16 = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("mrst.valid", 32'(ov16), 0);
    chk("mrst.out", {12'd0, d16, bo16, vf16, z16}, 0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("mrst.ready", 32'(ir16), 1);
    step();
    chk("mrst.idle", 32'(ov16), 0);

    op16("after", 16'h0010, 16'h0001,
         16'h000F, 1'b0, 1'b0, 1'b0, 1'b1);

    iv4 = 1'b1;
    a4  = 4'h3;
    b4  = 4'h5;
    step();
    iv4 = 1'b0;
    step();
    chk("w4.lat", 32'(ov4), 1);
    chk("w4.out", {25'd0, d4, bo4, vf4, z4},
        {25'd0, 4'hE, 3'b100});
    or4 = 1'b1;
    step();
    or4 = 1'b0;
    chk("w4.drop", 32'(ov4), 0);

    iv4 = 1'b1;
    or4 = 1'b1;
    a4  = 4'h3;
    b4  = 4'h5;
    for (int k = 0; k < 20 && acc.size() < 2; k++) begin
      if (ir4) acc.push_back(k);
      if (acc.size() < 2) step();
    end
    step();
    iv4 = 1'b0;
    chk("b2b.count", 32'(acc.size()), 2);
    if (acc.size() == 2)
      chk("b2b.gap", 32'(acc[1] - acc[0]), 3);
    step();
    chk("b2b.out", {25'd0, d4, bo4, vf4, z4},
        {25'd0, 4'hE, 3'b100});
    step();
    step();
    or4 = 1'b0;
    chk("b2b.idle", 32'(ir4), 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
